// File: rtl/mips_regfile_pkg.sv
// Shared types and constants for the MIPS general-purpose register file.
// Decode also uses the named register indices.
package mips_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32'(1) << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t REG_ZERO = 5'd0;
  localparam addr_t REG_SP   = 5'd29;
  localparam addr_t REG_RA   = 5'd31;

  // Write-port request as presented by writeback
  typedef struct packed {
    logic  en;
    addr_t addr;
    word_t data;
  } wr_req_t;

endpackage

// File: rtl/mips_regfile_if.sv
// Register-file access bus: two read ports (A, B) and one write port (C).
// The master is the pipeline; the slave is the register file.
interface mips_regfile_if;
  import mips_regfile_pkg::*;

  addr_t addra;
  word_t dataa;
  addr_t addrb;
  word_t datab;
  logic  enc;
  addr_t addrc;
  word_t datac;

  modport master (
    output addra, addrb, enc, addrc, datac,
    input  dataa, datab
  );

  modport slave (
    input  addra, addrb, enc, addrc, datac,
    output dataa, datab
  );

endinterface

// File: rtl/mips_regfile_read_mux.sv
// Combinational read port: selects one register and forces $0 to read zero
// regardless of what the array holds.
module mips_regfile_read_mux
  import mips_regfile_pkg::*;
(
  input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
  input  addr_t                        addr_i,
  output word_t                        rdata_c_o
);

  always_comb begin
    rdata_c_o = '0;
    if (addr_i != REG_ZERO) begin
      rdata_c_o = regs_i[addr_i];
    end
  end

endmodule

// File: rtl/mips_regfile.sv
// 32 x 32 MIPS register file: two zero-latency read ports, one synchronous
// write port, $0 hardwired to zero, no read-during-write bypass.
module mips_regfile
  import mips_regfile_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  mips_regfile_if.slave   bus
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;
  logic [DEPTH-1:0][DATA_W-1:0] regs_d;
  wr_req_t                      wr_c;

  assign wr_c = '{en: bus.enc, addr: bus.addrc, data: bus.datac};

  // Next array contents; writes to $0 are dropped here
  always_comb begin
    regs_d = regs_q;
    if (wr_c.en && (wr_c.addr != REG_ZERO)) begin
      regs_d[wr_c.addr] = wr_c.data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  mips_regfile_read_mux u_read_a (
    .regs_i    (regs_q),
    .addr_i    (bus.addra),
    .rdata_c_o (bus.dataa)
  );

  mips_regfile_read_mux u_read_b (
    .regs_i    (regs_q),
    .addr_i    (bus.addrb),
    .rdata_c_o (bus.datab)
  );

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: directed scenarios plus randomized
// traffic compared against an array-based model of the register file.
module tb_mips_regfile;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  logic [31:0] model [32];

  mips_regfile_if bus ();

  mips_regfile dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] ref_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // One write through port C on the next rising edge, mirrored in the model
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.enc   = 1'b1;
    bus.addrc = a;
    bus.datac = d;
    @(posedge clock);
    #1;
    if (reset && a != 5'd0) model[a] = d;
    bus.enc = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    wr(5'd7, 32'h1234);
    @(negedge clock);
    bus.addra = 5'd7;
    bus.addrb = 5'd7;
    #1;
    total++;
    if (bus.dataa !== 32'h1234) begin
      bad++; $display("FAIL preload_r7: got %h want %h", bus.dataa, 32'h1234);
    end
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    total++;
    if (bus.dataa !== 32'h0 || bus.datab !== 32'h0) begin
      bad++; $display("FAIL async_reset: got a=%h b=%h want 0", bus.dataa, bus.datab);
    end
    for (int i = 0; i < 32; i++) begin
      bus.addra = 5'(i);
      #1;
      got = bus.dataa;
      total++;
      if (got !== 32'h0) begin
        bad++; $display("FAIL reset_all r%0d: got %h want 0", i, got);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clock);
    bus.addrb = 5'd7;
    bus.enc   = 1'b1;
    bus.addrc = 5'd7;
    bus.datac = 32'h233;
    #1;
    total++;
    if (bus.datab !== 32'h0) begin
      bad++; $display("FAIL basic_before_edge: got %h want 0", bus.datab);
    end
    @(posedge clock);
    #1;
    model[7] = 32'h233;
    total++;
    if (bus.datab !== 32'h233) begin
      bad++; $display("FAIL basic_after_edge: got %h want %h", bus.datab, 32'h233);
    end
    @(negedge clock);
    bus.enc   = 1'b0;
    bus.datac = 32'hFFFF;
    @(posedge clock);
    #1;
    total++;
    if (bus.datab !== 32'h233) begin
      bad++; $display("FAIL basic_enc_low: got %h want %h", bus.datab, 32'h233);
    end
  endtask

  task automatic test_zero();
    wr(5'd0, 32'hDEADBEEF);
    bus.addra = 5'd0;
    #1;
    total++;
    if (bus.dataa !== 32'h0) begin
      bad++; $display("FAIL zero_reg: got %h want 0", bus.dataa);
    end
  endtask

  task automatic test_dual_read();
    wr(5'd1, 32'h11111111);
    wr(5'd31, 32'hFFFFFFFF);
    bus.addra = 5'd1;
    bus.addrb = 5'd31;
    #1;
    total++;
    if (bus.dataa !== 32'h11111111 || bus.datab !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL dual_read: got a=%h b=%h want a=11111111 b=ffffffff",
                      bus.dataa, bus.datab);
    end
    bus.addra = 5'd31;
    #1;
    total++;
    if (bus.dataa !== 32'hFFFFFFFF || bus.datab !== 32'hFFFFFFFF) begin
      bad++; $display("FAIL same_addr_read: got a=%h b=%h want ffffffff", bus.dataa, bus.datab);
    end
  endtask

  task automatic test_back_to_back();
    wr(5'd5, 32'hA);
    wr(5'd5, 32'hB);
    bus.addra = 5'd5;
    #1;
    total++;
    if (bus.dataa !== 32'hB) begin
      bad++; $display("FAIL overwrite: got %h want %h", bus.dataa, 32'hB);
    end
    @(negedge clock);
    bus.enc   = 1'b0;
    bus.addrc = 5'd5;
    bus.datac = 32'hC;
    @(posedge clock);
    #1;
    total++;
    if (bus.dataa !== 32'hB) begin
      bad++; $display("FAIL enable_gating: got %h want %h", bus.dataa, 32'hB);
    end
  endtask

  task automatic test_reset_during_write();
    wr(5'd9, 32'h77);
    @(negedge clock);
    bus.enc   = 1'b1;
    bus.addrc = 5'd9;
    bus.datac = 32'h55;
    #3;
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    @(negedge clock);
    bus.enc = 1'b0;
    reset   = 1'b1;
    bus.addra = 5'd9;
    #1;
    total++;
    if (bus.dataa !== 32'h0) begin
      bad++; $display("FAIL reset_during_write: got %h want 0", bus.dataa);
    end
  endtask

  task automatic test_random();
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        we;
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      we = 1'($urandom_range(0, 3) != 0);
      wa = 5'($urandom);
      wd = $urandom;
      bus.enc   = we;
      bus.addrc = wa;
      bus.datac = wd;
      bus.addra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      bus.addrb = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #1;
      total++;
      if (bus.dataa !== ref_rd(bus.addra) || bus.datab !== ref_rd(bus.addrb)) begin
        bad++; $display("FAIL rand_pre[%0d]: got a=%h b=%h want a=%h b=%h", n,
                        bus.dataa, bus.datab, ref_rd(bus.addra), ref_rd(bus.addrb));
      end
      @(posedge clock);
      #1;
      if (we && wa != 5'd0) model[wa] = wd;
      total++;
      if (bus.dataa !== ref_rd(bus.addra) || bus.datab !== ref_rd(bus.addrb)) begin
        bad++; $display("FAIL rand_post[%0d]: got a=%h b=%h want a=%h b=%h", n,
                        bus.dataa, bus.datab, ref_rd(bus.addra), ref_rd(bus.addrb));
      end
    end
    bus.enc = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    model_clear();
    reset     = 1'b0;
    bus.addra = '0;
    bus.addrb = '0;
    bus.enc   = 1'b0;
    bus.addrc = '0;
    bus.datac = '0;
    #1;
    total++;
    if (bus.dataa !== 32'h0 || bus.datab !== 32'h0) begin
      bad++; $display("FAIL initial_reset: got a=%h b=%h want 0", bus.dataa, bus.datab);
    end
    @(negedge clock);
    reset = 1'b1;
    test_reset();
    test_basic();
    test_zero();
    test_dual_read();
    test_back_to_back();
    test_reset_during_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
